// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register file slice.
// Build option: REGFILE_BYPASS_EN enables write-through reads.
package regfile_pkg;

    localparam int PKG_ADDR_WIDTH = 5;
    localparam int MAX_REGS = 256;

    typedef logic [PKG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [31:0] reg_data_t;

    localparam reg_addr_t REG_ZERO = '0;

    function automatic logic [8:0] popcount(
        input logic [MAX_REGS-1:0] v
    );
        logic [8:0] c;
        c = '0;
        for (int i = 0; i < MAX_REGS; i++) begin
            c = c + {8'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read, write and claim bundle between pipeline and register file.
// Build option: REGFILE_BYPASS_EN (affects read timing only).
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);

    logic [NUM_RD-1:0]            rd_en;
    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_busy;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic                         claim_en;
    logic [ADDR_WIDTH-1:0]        claim_addr;
    logic [ADDR_WIDTH:0]          busy_count;
    logic                         any_busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output claim_en, claim_addr,
        input  rd_data, rd_busy, busy_count, any_busy
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  claim_en, claim_addr,
        output rd_data, rd_busy, busy_count, any_busy
    );

endinterface

// File: rtl/regfile_scoreboard_bits.sv
// Per-register busy bits with claim-over-clear priority and a count.
// Build option: REGFILE_BYPASS_EN has no effect here.
module regfile_scoreboard_bits
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_WR = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_WR-1:0]            wrEn,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wrAddr,
    input  logic                         claimEn,
    input  logic [ADDR_WIDTH-1:0]        claimAddr,
    output logic [(1<<ADDR_WIDTH)-1:0]   busy,
    output logic [ADDR_WIDTH:0]          busyCount,
    output logic                         anyBusy
);

    localparam int NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0]    busyNext;
    logic [MAX_REGS-1:0] busyWide;
    logic [8:0]          nextCount;

    // Retire on write, then let a same-cycle claim win.
    always_comb begin
        busyNext = busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wrEn[j]) begin
                busyNext[wrAddr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (claimEn && claimAddr != ADDR_WIDTH'(REG_ZERO)) begin
            busyNext[claimAddr] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    // Count the post-edge busy set so the register lines up with it.
    always_comb begin
        busyWide = '0;
        busyWide[NREGS-1:0] = busyNext;
        nextCount = popcount(busyWide);
    end

    // Busy vector and its population count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy      <= '0;
            busyCount <= '0;
        end else begin
            busy      <= busyNext;
            busyCount <= (ADDR_WIDTH+1)'(nextCount);
        end
    end

    assign anyBusy = (busyCount != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file, r0 hardwired to zero, with busy scoreboard.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writes to reads.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input logic clock,
    input logic reset,
    regfile_scoreboard_if.slave bus
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0]        regs [NREGS];
    logic [NREGS-1:0]             busy;
    logic [NUM_RD*DATA_WIDTH-1:0] rdData;
    logic [NUM_RD-1:0]            rdBusy;
    logic [ADDR_WIDTH-1:0]        ra;
    logic [ADDR_WIDTH-1:0]        wa;
    logic [ADDR_WIDTH:0]          busyCount;
    logic                         anyBusy;

    regfile_scoreboard_bits #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_WR    (NUM_WR)
    ) u_bits (
        .clock    (clock),
        .reset    (reset),
        .wrEn     (bus.wr_en),
        .wrAddr   (bus.wr_addr),
        .claimEn  (bus.claim_en),
        .claimAddr(bus.claim_addr),
        .busy     (busy),
        .busyCount(busyCount),
        .anyBusy  (anyBusy)
    );

    // Storage; later ports overwrite earlier ones on a collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] &&
                    bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != ZERO) begin
                    regs[bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] <=
                        bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Combinational read ports; disabled ports and r0 read as zero.
    always_comb begin
        rdData = '0;
        rdBusy = '0;
        ra     = '0;
        wa     = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = bus.rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            if (bus.rd_en[i] && ra != ZERO) begin
                rdData[i*DATA_WIDTH +: DATA_WIDTH] = regs[ra];
                rdBusy[i] = busy[ra];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NUM_WR; j++) begin
                    wa = bus.wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                    if (bus.wr_en[j] && wa == ra) begin
                        rdData[i*DATA_WIDTH +: DATA_WIDTH] =
                            bus.wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                        rdBusy[i] = bus.claim_en &&
                                    (bus.claim_addr == ra);
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_data    = rdData;
    assign bus.rd_busy    = rdBusy;
    assign bus.busy_count = busyCount;
    assign bus.any_busy   = anyBusy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard.
// Honours REGFILE_BYPASS_EN for same-cycle read expectations.
module tb_regfile_scoreboard;

    import regfile_pkg::*;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    regfile_scoreboard_if #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)
    ) bus ();

    regfile_scoreboard #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .NUM_WR(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] mMem  [32];
    logic        mBusy [32];

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ce;
        logic [4:0]  ca;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        for (int a = 0; a < 32; a++) begin
            mMem[a]  = '0;
            mBusy[a] = 1'b0;
        end
    endtask

    function automatic int modelCount();
        int n;
        n = 0;
        for (int a = 1; a < 32; a++) n += int'(mBusy[a]);
        return n;
    endfunction

    task automatic idle();
        bus.wr_en      = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.claim_en   = 1'b0;
        bus.claim_addr = '0;
    endtask

    task automatic tick();
        logic [1:0]  we;
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic        ce;
        logic [4:0]  ca;
        we = bus.wr_en;
        for (int j = 0; j < 2; j++) begin
            wa[j] = bus.wr_addr[j*5 +: 5];
            wd[j] = bus.wr_data[j*32 +: 32];
        end
        ce = bus.claim_en;
        ca = bus.claim_addr;
        @(posedge clock);
        #1;
        for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j] != 0) begin
                mMem[wa[j]]  = wd[j];
                mBusy[wa[j]] = 1'b0;
            end
        end
        if (ce && ca != 0) mBusy[ca] = 1'b1;
    endtask

    task automatic expRead(input int i, output logic [31:0] d,
                           output logic b);
        logic [4:0] a;
        a = bus.rd_addr[i*5 +: 5];
        d = '0;
        b = 1'b0;
        if (bus.rd_en[i] && a != 0) begin
            d = mMem[a];
            b = mBusy[a];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < 2; j++) begin
                if (bus.wr_en[j] && bus.wr_addr[j*5 +: 5] == a) begin
                    d = bus.wr_data[j*32 +: 32];
                    b = bus.claim_en && bus.claim_addr == a;
                end
            end
`endif
        end
    endtask

    task automatic checkReads(input string tag);
        logic [31:0] d;
        logic        b;
        for (int i = 0; i < 2; i++) begin
            expRead(i, d, b);
            check({tag, "_data"}, bus.rd_data[i*32 +: 32], d);
            check({tag, "_busy"}, 32'(bus.rd_busy[i]), 32'(b));
        end
    endtask

    initial begin
        logic [31:0] e;
        compared   = 0;
        mismatched = 0;
        modelClear();
        idle();
        bus.rd_en   = '1;
        bus.rd_addr = '0;
        reset = 1'b1;
        #12;
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int a = 0; a < 32; a++) begin
            bus.rd_addr = {5'(a), 5'(31 - a)};
            #1;
            check("rst_rd0", bus.rd_data[31:0], 32'd0);
            check("rst_rd1", bus.rd_data[63:32], 32'd0);
            check("rst_busy", 32'(bus.rd_busy), 32'd0);
        end
        check("rst_cnt", 32'(bus.busy_count), 32'd0);
        check("rst_any", 32'(bus.any_busy), 32'd0);

        vecs[0] = '{2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0,
                    5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 6'd0};
        vecs[1] = '{2'b01, 5'd0, 32'h00001234, 5'd0, 32'd0, 1'b0, 5'd0,
                    5'd0, 5'd5, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        vecs[2] = '{2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF,
                    1'b0, 5'd0, 5'd7, 5'd5, 32'h5555FFFF, 32'hDEADBEEF,
                    1'b0, 1'b0, 6'd0};
        vecs[3] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9,
                    5'd9, 5'd7, 32'd0, 32'h5555FFFF, 1'b1, 1'b0, 6'd1};
        vecs[4] = '{2'b01, 5'd9, 32'h00000042, 5'd0, 32'd0, 1'b0, 5'd0,
                    5'd9, 5'd0, 32'h42, 32'd0, 1'b0, 1'b0, 6'd0};
        vecs[5] = '{2'b10, 5'd0, 32'd0, 5'd9, 32'h00000077, 1'b1, 5'd9,
                    5'd9, 5'd9, 32'h77, 32'h77, 1'b1, 1'b1, 6'd1};
        vecs[6] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd0,
                    5'd0, 5'd9, 32'd0, 32'h77, 1'b0, 1'b1, 6'd1};
        vecs[7] = '{2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9,
                    5'd9, 5'd0, 32'h77, 32'd0, 1'b1, 1'b0, 6'd1};
        vecs[8] = '{2'b11, 5'd9, 32'h00000005, 5'd10, 32'h00000006,
                    1'b1, 5'd10, 5'd9, 5'd10, 32'h5, 32'h6,
                    1'b0, 1'b1, 6'd1};

        for (int v = 0; v < 9; v++) begin
            bus.wr_en      = vecs[v].wen;
            bus.wr_addr    = {vecs[v].wa1, vecs[v].wa0};
            bus.wr_data    = {vecs[v].wd1, vecs[v].wd0};
            bus.claim_en   = vecs[v].ce;
            bus.claim_addr = vecs[v].ca;
            tick();
            idle();
            bus.rd_en   = '1;
            bus.rd_addr = {vecs[v].ra1, vecs[v].ra0};
            #1;
            check("vec_rd0", bus.rd_data[31:0], vecs[v].ed0);
            check("vec_rd1", bus.rd_data[63:32], vecs[v].ed1);
            check("vec_bz0", 32'(bus.rd_busy[0]), 32'(vecs[v].eb0));
            check("vec_bz1", 32'(bus.rd_busy[1]), 32'(vecs[v].eb1));
            check("vec_cnt", 32'(bus.busy_count), 32'(vecs[v].ecnt));
            check("vec_any", 32'(bus.any_busy),
                  32'(vecs[v].ecnt != 0));
        end

        bus.rd_en   = 2'b00;
        bus.rd_addr = {5'd10, 5'd5};
        #1;
        check("rden_off_data", bus.rd_data[31:0], 32'd0);
        check("rden_off_busy", 32'(bus.rd_busy), 32'd0);

        bus.rd_en      = 2'b01;
        bus.rd_addr    = {5'd0, 5'd3};
        bus.wr_en      = 2'b01;
        bus.wr_addr    = {5'd0, 5'd3};
        bus.wr_data    = {32'd0, 32'hCAFEF00D};
`ifdef REGFILE_BYPASS_EN
        e = 32'hCAFEF00D;
`else
        e = 32'd0;
`endif
        #1;
        check("same_cyc_data", bus.rd_data[31:0], e);
        check("same_cyc_busy", 32'(bus.rd_busy[0]), 32'd0);
        tick();
        idle();
        #1;
        check("after_wr_r3", bus.rd_data[31:0], 32'hCAFEF00D);

        for (int n = 0; n < 200; n++) begin
            bus.wr_en      = 2'($urandom_range(0, 3));
            bus.wr_addr    = {5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7))};
            bus.wr_data    = {$urandom, $urandom};
            bus.claim_en   = 1'($urandom_range(0, 1));
            bus.claim_addr = 5'($urandom_range(0, 7));
            bus.rd_en      = 2'($urandom_range(0, 3));
            bus.rd_addr    = {5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7))};
            #1;
            checkReads("rnd");
            tick();
            check("rnd_cnt", 32'(bus.busy_count), 32'(modelCount()));
            check("rnd_any", 32'(bus.any_busy),
                  32'(modelCount() != 0));
        end

        idle();
        for (int a = 1; a <= 4; a++) begin
            bus.wr_en   = 2'b01;
            bus.wr_addr = {5'd0, 5'(a)};
            bus.wr_data = {32'd0, 32'h100 + 32'(a)};
            tick();
        end
        idle();
        for (int a = 1; a <= 2; a++) begin
            bus.claim_en   = 1'b1;
            bus.claim_addr = 5'(a);
            tick();
        end
        check("pre_rst_cnt", 32'(bus.busy_count), 32'(modelCount()));
        bus.claim_addr = 5'd3;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_cnt", 32'(bus.busy_count), 32'd0);
        check("mid_rst_any", 32'(bus.any_busy), 32'd0);
        bus.rd_en   = '1;
        bus.rd_addr = {5'd2, 5'd1};
        #1;
        check("mid_rst_r1", bus.rd_data[31:0], 32'd0);
        check("mid_rst_r2", bus.rd_data[63:32], 32'd0);
        check("mid_rst_bz", 32'(bus.rd_busy), 32'd0);
        bus.rd_addr = {5'd4, 5'd3};
        #1;
        check("mid_rst_r3", bus.rd_data[31:0], 32'd0);
        check("mid_rst_r4", bus.rd_data[63:32], 32'd0);
        idle();
        modelClear();
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("post_rst_cnt", 32'(bus.busy_count), 32'd0);
        checkReads("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
